// File: rtl/pc_context_scheduler_if.sv
// pc_context_scheduler_if: PC-block side bus of the scheduler.
// slave = scheduler, master = PC block / OS / loader.
interface pc_context_scheduler_if #(
  parameter int NPROC = 4
) ();
  localparam int IW = $clog2(NPROC);

  logic             load_en;
  logic [IW-1:0]    load_id;
  logic [31:0]      load_pc;
  logic             retire;
  logic             io_stall;
  logic             proc_exit;
  logic             os_done;
  logic [31:0]      pc_current;
  logic             pc_load;
  logic [31:0]      pc_target;
  logic             in_program;
  logic [IW-1:0]    cur_id;
  logic             ctx_switch;
  logic [NPROC-1:0] valid;

  modport master (
    output load_en, load_id, load_pc, retire, io_stall,
    output proc_exit, os_done, pc_current,
    input  pc_load, pc_target, in_program, cur_id,
    input  ctx_switch, valid
  );

  modport slave (
    input  load_en, load_id, load_pc, retire, io_stall,
    input  proc_exit, os_done, pc_current,
    output pc_load, pc_target, in_program, cur_id,
    output ctx_switch, valid
  );
endinterface

// File: rtl/pc_context_scheduler.sv
// pc_context_scheduler: time-slice PC sequencer between the OS
// handler and NPROC user processes, round-robin dispatch.
module pc_context_scheduler #(
  parameter int          NPROC    = 4,
  parameter int          QUANTUM  = 10,
  parameter logic [31:0] OS_ENTRY = 32'h0000_0000
) (
  input logic                   CLK,
  input logic                   reset,
  pc_context_scheduler_if.slave bus
);
  localparam int IW = $clog2(NPROC);

  typedef enum logic [1:0] {
    IDLE, DISPATCH, RUN, OS
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    cur_id_q, cur_id_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [NPROC-1:0] valid_q, valid_d;
  logic [31:0]      saved_pc_q [NPROC];
  logic [31:0]      saved_pc_d [NPROC];
  logic             pc_load_q, pc_load_d;
  logic [31:0]      pc_target_q, pc_target_d;
  logic             in_program_q, in_program_d;
  logic             ctx_switch_q, ctx_switch_d;

  logic             found;
  logic [IW-1:0]    sel;
  logic [IW-1:0]    srch_idx;
  logic             enter_os;
  logic             load_ok;

  // round-robin search: scan from far to near so nearest valid wins
  always_comb begin
    found    = 1'b0;
    sel      = cur_id_q;
    srch_idx = cur_id_q;
    for (int k = NPROC; k >= 1; k--) begin
      srch_idx = IW'((int'(cur_id_q) + k) % NPROC);
      if (valid_q[srch_idx]) begin
        found = 1'b1;
        sel   = srch_idx;
      end
    end
  end

  // next-state, slot table and registered output computation
  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    saved_pc_d   = saved_pc_q;
    pc_load_d    = 1'b0;
    pc_target_d  = pc_target_q;
    in_program_d = in_program_q;
    ctx_switch_d = 1'b0;
    enter_os     = 1'b0;
    load_ok      = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_program_d = 1'b0;
        if (|valid_q) state_d = DISPATCH;
      end
      DISPATCH: begin
        if (found) begin
          cur_id_d     = sel;
          pc_target_d  = saved_pc_q[sel];
          pc_load_d    = 1'b1;
          in_program_d = 1'b1;
          cnt_d        = 8'd0;
          state_d      = RUN;
        end else begin
          in_program_d = 1'b0;
          state_d      = IDLE;
        end
      end
      RUN: begin
        if (bus.retire && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        if (bus.proc_exit) begin
          valid_d[cur_id_q] = 1'b0;
          enter_os          = 1'b1;
        end else if (cnt_q >= 8'(QUANTUM) && !bus.io_stall) begin
          saved_pc_d[cur_id_q] = bus.pc_current;
          enter_os             = 1'b1;
        end
      end
      OS: begin
        if (bus.os_done) state_d = DISPATCH;
      end
      default: state_d = IDLE;
    endcase

    if (enter_os) begin
      pc_target_d  = OS_ENTRY;
      pc_load_d    = 1'b1;
      ctx_switch_d = 1'b1;
      in_program_d = 1'b0;
      state_d      = OS;
    end

    // the running slot's PC lives in the PC block, so loads to it drop
    load_ok = bus.load_en &&
              !(state_q == RUN && bus.load_id == cur_id_q);
    if (load_ok) begin
      valid_d[bus.load_id]    = 1'b1;
      saved_pc_d[bus.load_id] = bus.load_pc;
    end
  end

  // state and output registers
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cur_id_q     <= '0;
      cnt_q        <= 8'd0;
      valid_q      <= '0;
      pc_load_q    <= 1'b0;
      pc_target_q  <= 32'd0;
      in_program_q <= 1'b0;
      ctx_switch_q <= 1'b0;
      for (int i = 0; i < NPROC; i++) saved_pc_q[i] <= 32'd0;
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      pc_load_q    <= pc_load_d;
      pc_target_q  <= pc_target_d;
      in_program_q <= in_program_d;
      ctx_switch_q <= ctx_switch_d;
      for (int i = 0; i < NPROC; i++) saved_pc_q[i] <= saved_pc_d[i];
    end
  end

  assign bus.pc_load    = pc_load_q;
  assign bus.pc_target  = pc_target_q;
  assign bus.in_program = in_program_q;
  assign bus.cur_id     = cur_id_q;
  assign bus.ctx_switch = ctx_switch_q;
  assign bus.valid      = valid_q;
endmodule

// File: tb/tb_pc_context_scheduler.sv
// tb_pc_context_scheduler: directed stimulus with a queue scoreboard
// checked by a monitor on every pc_load strobe.
module tb_pc_context_scheduler;
  logic CLK;
  logic reset;

  pc_context_scheduler_if #(.NPROC(4)) bus ();

  pc_context_scheduler #(
    .NPROC(4), .QUANTUM(10), .OS_ENTRY(32'h0)
  ) dut (
    .CLK(CLK), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [31:0] tgt;
    logic        inp;
    logic [1:0]  id;
    logic        ctx;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   loads_seen = 0;
  int   loads_exp = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(logic [31:0] tgt, logic inp,
                      logic [1:0] id, logic ctx);
    exp_t e;
    e.tgt = tgt; e.inp = inp; e.id = id; e.ctx = ctx;
    sb.push_back(e);
    loads_exp++;
  endtask

  // monitor: each pc_load strobe must match the oldest expectation
  always @(negedge CLK) begin
    if (reset && bus.pc_load) begin
      loads_seen++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pc_load: got target %h expected none",
                 bus.pc_target);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc_target", bus.pc_target, e.tgt);
        chk("sb_in_program", 32'(bus.in_program), 32'(e.inp));
        chk("sb_cur_id", 32'(bus.cur_id), 32'(e.id));
        chk("sb_ctx_switch", 32'(bus.ctx_switch), 32'(e.ctx));
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_load(string name);
    for (int i = 0; i < 20; i++) begin
      if (loads_seen >= loads_exp) return;
      step();
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0d loads expected %0d", name,
             loads_seen, loads_exp);
  endtask

  task automatic load(logic [1:0] id, logic [31:0] pc);
    step();
    bus.load_en = 1'b1;
    bus.load_id = id;
    bus.load_pc = pc;
    step();
    bus.load_en = 1'b0;
  endtask

  task automatic retires(int n);
    for (int i = 0; i < n; i++) begin
      step();
      bus.retire = 1'b1;
    end
    step();
    bus.retire = 1'b0;
  endtask

  task automatic pulse_os_done();
    step();
    bus.os_done = 1'b1;
    step();
    bus.os_done = 1'b0;
  endtask

  task automatic pulse_exit();
    step();
    bus.proc_exit = 1'b1;
    step();
    bus.proc_exit = 1'b0;
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_pc_load"}, 32'(bus.pc_load), 32'd0);
    chk({tag, "_pc_target"}, bus.pc_target, 32'd0);
    chk({tag, "_in_program"}, 32'(bus.in_program), 32'd0);
    chk({tag, "_cur_id"}, 32'(bus.cur_id), 32'd0);
    chk({tag, "_ctx_switch"}, 32'(bus.ctx_switch), 32'd0);
    chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
  endtask

  initial begin
    reset          = 1'b0;
    bus.load_en    = 1'b0;
    bus.load_id    = '0;
    bus.load_pc    = '0;
    bus.retire     = 1'b0;
    bus.io_stall   = 1'b0;
    bus.proc_exit  = 1'b0;
    bus.os_done    = 1'b0;
    bus.pc_current = '0;

    repeat (3) step();
    chk_reset_outs("reset");
    reset = 1'b1;

    // first dispatch starts at cur_id+1 = 1
    push(32'h200, 1'b1, 2'd1, 1'b0);
    step();
    bus.load_en = 1'b1; bus.load_id = 2'd0; bus.load_pc = 32'h100;
    step();
    bus.load_id = 2'd1; bus.load_pc = 32'h200;
    step();
    bus.load_en = 1'b0;
    chk("valid_after_loads", 32'(bus.valid), 32'h3);
    wait_load("first_dispatch");

    // quantum expiry of slot1
    bus.pc_current = 32'h228;
    push(32'h0, 1'b0, 2'd1, 1'b1);
    retires(10);
    wait_load("expiry_slot1");

    // os_done: slot0 next
    push(32'h100, 1'b1, 2'd0, 1'b0);
    pulse_os_done();
    wait_load("dispatch_slot0");

    // expiry held off by io_stall
    bus.pc_current = 32'h140;
    for (int i = 0; i < 10; i++) begin
      step();
      bus.retire = 1'b1;
      bus.io_stall = 1'b1;
    end
    step();
    bus.retire = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_no_switch", 32'(bus.pc_load), 32'd0);
    end
    push(32'h0, 1'b0, 2'd0, 1'b1);
    bus.io_stall = 1'b0;
    step();
    chk("stall_release_switch", 32'(bus.pc_load), 32'd1);

    // slot1 resumes at its saved PC
    push(32'h228, 1'b1, 2'd1, 1'b0);
    pulse_os_done();
    wait_load("resume_slot1");

    // load to the running slot is dropped
    load(2'd1, 32'hDEAD0);
    chk("valid_run_load", 32'(bus.valid), 32'h3);
    bus.pc_current = 32'h250;
    push(32'h0, 1'b0, 2'd1, 1'b1);
    retires(10);
    wait_load("expiry_slot1b");

    push(32'h140, 1'b1, 2'd0, 1'b0);
    pulse_os_done();
    wait_load("resume_slot0");

    // exit together with a load to the running slot
    push(32'h0, 1'b0, 2'd0, 1'b1);
    step();
    bus.proc_exit = 1'b1;
    bus.load_en = 1'b1; bus.load_id = 2'd0; bus.load_pc = 32'h999;
    step();
    bus.proc_exit = 1'b0;
    bus.load_en = 1'b0;
    wait_load("exit_slot0");
    chk("valid_after_exit0", 32'(bus.valid), 32'h2);

    push(32'h250, 1'b1, 2'd1, 1'b0);
    pulse_os_done();
    wait_load("resume_slot1b");

    // load another slot while running, then exit down to slot2 only
    load(2'd2, 32'h300);
    chk("valid_load_other", 32'(bus.valid), 32'h6);
    push(32'h0, 1'b0, 2'd1, 1'b1);
    pulse_exit();
    wait_load("exit_slot1");
    push(32'h300, 1'b1, 2'd2, 1'b0);
    pulse_os_done();
    wait_load("dispatch_slot2");

    push(32'h0, 1'b0, 2'd2, 1'b1);
    pulse_exit();
    wait_load("exit_slot2");
    chk("valid_empty", 32'(bus.valid), 32'h0);
    pulse_os_done();
    repeat (4) step();
    chk("idle_in_program", 32'(bus.in_program), 32'd0);
    chk("idle_no_load", 32'(loads_seen), 32'(loads_exp));
    chk("idle_cur_id", 32'(bus.cur_id), 32'd2);

    // dispatch from IDLE then reset while in OS
    push(32'h400, 1'b1, 2'd3, 1'b0);
    load(2'd3, 32'h400);
    wait_load("dispatch_slot3");
    bus.pc_current = 32'h480;
    push(32'h0, 1'b0, 2'd3, 1'b1);
    retires(10);
    wait_load("expiry_slot3");
    reset = 1'b0;
    #1;
    chk_reset_outs("midreset");
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();
    chk("post_reset_in_program", 32'(bus.in_program), 32'd0);
    chk("post_reset_valid", 32'(bus.valid), 32'd0);
    chk("post_reset_loads", 32'(loads_seen), 32'(loads_exp));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
